// File: rtl/pipe_mem_hazard_ctrl.sv
// pipe_mem_hazard_ctrl
// Stall/flush sequencer for the 5-stage MIPS pipeline. It inserts one bubble
// per load-use hazard between ID and EXE, and it runs the data-memory req/ack
// handshake for the instruction in the EXE/MEM register. The whole pipeline
// is frozen until that access completes.
// Optional feature macro: MEM_TIMEOUT_EN. It adds an ACCESS wait counter, a
// terminal ERROR state and a sticky dm_err flag.
// The hold/flush outputs and dm_req are combinational, so that an ack
// releases the pipeline on the same edge. All of them are forced low while
// rst_n is low.
module pipe_mem_hazard_ctrl #(
    parameter int unsigned STALL_CNT_W = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             ID_Rs,
    input  logic [4:0]             ID_Rt,
    input  logic                   ID_UsesRs,
    input  logic                   ID_UsesRt,
    input  logic [4:0]             EXE_Rw,
    input  logic                   EXE_RfWr,
    input  logic [1:0]             EXE_WbSel,
    input  logic [1:0]             MEM_WbSel,
    input  logic                   MEM_DmWr,
    input  logic                   dm_ack,
    output logic                   dm_req,
    output logic                   pc_hold,
    output logic                   ifid_hold,
    output logic                   idexe_hold,
    output logic                   idexe_flush,
    output logic                   exemem_hold,
    output logic                   memwb_flush,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic                   dm_err
);

`ifdef MEM_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        ERROR  = 2'b10
    } state_t;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);
`else
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01
    } state_t;
`endif

    state_t                 state_r;
    state_t                 state_next_s;
    logic                   mem_op_s;
    logic                   lu_haz_s;
    logic                   req_s;
    logic                   err_state_s;
    logic                   mem_stall_s;
    logic [STALL_CNT_W-1:0] stall_cnt_r;

    // A load in EXE whose destination is a live source of the ID instruction.
    // A load to $0 never stalls.
    function automatic logic load_use_hazard(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rs,
        input logic       uses_rt,
        input logic [4:0] rw,
        input logic       rf_wr,
        input logic [1:0] wb_sel
    );
        logic is_load;
        logic src_hit;
        is_load = rf_wr & (wb_sel == 2'b01) & (rw != 5'd0);
        src_hit = (uses_rs & (rs == rw)) | (uses_rt & (rt == rw));
        return is_load & src_hit;
    endfunction

    assign mem_op_s = (MEM_WbSel == 2'b01) | MEM_DmWr;
    assign lu_haz_s = load_use_hazard(ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt,
                                      EXE_Rw, EXE_RfWr, EXE_WbSel);

`ifdef MEM_TIMEOUT_EN
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              dm_err_r;
`else
    // TIMEOUT_CYC only matters when the timeout logic is built.
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT_CYC == 32'd0);
`endif

    // State register for the handshake sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and raw request/error decode.
    always_comb begin
        state_next_s = state_r;
        req_s        = 1'b0;
        err_state_s  = 1'b0;
        case (state_r)
            IDLE: begin
                req_s = mem_op_s;
                if (mem_op_s && !dm_ack) begin
                    state_next_s = ACCESS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS: begin
                req_s = 1'b1;
                if (dm_ack) begin
                    state_next_s = IDLE;
`ifdef MEM_TIMEOUT_EN
                end else if (wait_cnt_r == WAIT_W'(TIMEOUT_CYC - 1)) begin
                    state_next_s = ERROR;
`endif
                end else begin
                    state_next_s = ACCESS;
                end
            end
`ifdef MEM_TIMEOUT_EN
            ERROR: begin
                // Terminal state: only rst_n leaves it. A late ack is ignored.
                req_s        = 1'b0;
                err_state_s  = 1'b1;
                state_next_s = ERROR;
            end
`endif
            default: begin
                req_s        = 1'b0;
                state_next_s = IDLE;
            end
        endcase
    end

    // An ack in the request cycle completes the access with no wait.
    assign mem_stall_s = req_s & ~dm_ack;

    // Hold/flush priority: error freeze, then memory stall, then load-use.
    // A memory stall suppresses the load-use bubble. The hazard is evaluated
    // again once the stall releases.
    always_comb begin
        dm_req      = 1'b0;
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        idexe_hold  = 1'b0;
        idexe_flush = 1'b0;
        exemem_hold = 1'b0;
        memwb_flush = 1'b0;
        if (!rst_n) begin
            dm_req      = 1'b0;
            pc_hold     = 1'b0;
        end else if (err_state_s || mem_stall_s) begin
            dm_req      = req_s;
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idexe_hold  = 1'b1;
            exemem_hold = 1'b1;
            memwb_flush = 1'b1;
        end else if (lu_haz_s) begin
            dm_req      = req_s;
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idexe_flush = 1'b1;
        end else begin
            dm_req      = req_s;
            pc_hold     = 1'b0;
        end
    end

    // Performance counter of cycles in which the PC is held. It wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if (pc_hold) begin
            stall_cnt_r <= stall_cnt_r + STALL_CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;

`ifdef MEM_TIMEOUT_EN
    // Counts ACCESS cycles and clears whenever ACCESS is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if ((state_r == ACCESS) && (state_next_s == ACCESS)) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end
    end

    // Sticky timeout flag. It is set on the edge that enters ERROR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_err_r <= 1'b0;
        end else if (state_next_s == ERROR) begin
            dm_err_r <= 1'b1;
        end else begin
            dm_err_r <= dm_err_r;
        end
    end

    assign dm_err = dm_err_r;
`else
    assign dm_err = 1'b0;
`endif

endmodule
